// File: rtl/hilo_muldiv_unit.sv
// HI/LO execute unit: MULT/MULTU (MUL_LAT cycles), DIV/DIVU (32-step restoring), MTHI/MTLO.
// Latency: mul 1+MUL_LAT, div 34, div-by-zero 1 stall cycles; stall holds EX until commit.
`ifndef MULT_CONTROL
`define MULT_CONTROL  5'd12
`endif
`ifndef MULTU_CONTROL
`define MULTU_CONTROL 5'd13
`endif
`ifndef DIV_CONTROL
`define DIV_CONTROL   5'd14
`endif
`ifndef DIVU_CONTROL
`define DIVU_CONTROL  5'd15
`endif
`ifndef MTHI_CONTROL
`define MTHI_CONTROL  5'd16
`endif
`ifndef MTLO_CONTROL
`define MTLO_CONTROL  5'd17
`endif

module hilo_muldiv_unit #(
  parameter int MUL_LAT = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [4:0]  alucontrol,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_opa;
  logic [31:0] r_opb;
  logic [31:0] r_rem;
  logic [31:0] r_quot;
  logic [4:0]  r_cnt;
  logic        r_mul_sgn;
  logic        r_neg_q;
  logic        r_neg_r;

  logic        w_is_mul;
  logic        w_is_div;
  logic        w_is_mthi;
  logic        w_is_mtlo;
  logic        w_sdiv;
  logic        w_mul_last;
  logic        w_div_last;
  logic        w_stall;
  logic [63:0] w_ext_a;
  logic [63:0] w_ext_b;
  logic [63:0] w_prod;
  logic [32:0] w_rem_sh;
  logic        w_ge;
  logic [31:0] w_rem_nxt;
  logic [31:0] w_quot_nxt;

  assign w_is_mul  = start && (alucontrol == `MULT_CONTROL || alucontrol == `MULTU_CONTROL);
  assign w_is_div  = start && (alucontrol == `DIV_CONTROL  || alucontrol == `DIVU_CONTROL);
  assign w_is_mthi = start && (alucontrol == `MTHI_CONTROL);
  assign w_is_mtlo = start && (alucontrol == `MTLO_CONTROL);
  assign w_sdiv    = (alucontrol == `DIV_CONTROL);

  assign w_mul_last = (r_cnt == 5'(MUL_LAT - 1));
  assign w_div_last = (r_cnt == 5'd31);

  assign w_ext_a = {{32{r_mul_sgn & r_opa[31]}}, r_opa};
  assign w_ext_b = {{32{r_mul_sgn & r_opb[31]}}, r_opb};
  assign w_prod  = w_ext_a * w_ext_b;

  // Shifted partial remainder can reach 33 bits before the trial subtract.
  assign w_rem_sh   = {r_rem, r_quot[31]};
  assign w_ge       = (w_rem_sh >= {1'b0, r_opb});
  assign w_rem_nxt  = w_ge ? (w_rem_sh[31:0] - r_opb) : w_rem_sh[31:0];
  assign w_quot_nxt = {r_quot[30:0], w_ge};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    if (flush) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_stall = w_is_mul || w_is_div;
          if (w_is_mul)      w_next = S_MUL;
          else if (w_is_div) w_next = (b == 32'd0) ? S_DONE : S_DIV;
        end
        S_MUL: begin
          w_stall = 1'b1;
          if (w_mul_last) w_next = S_DONE;
        end
        S_DIV: begin
          w_stall = 1'b1;
          if (w_div_last) w_next = S_FIX;
        end
        S_FIX: begin
          w_stall = 1'b1;
          w_next  = S_DONE;
        end
        S_DONE:  w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Stall must read low while reset is held, even if start is still asserted.
  assign stall = resetn && w_stall;
  assign done  = (r_state == S_DONE) && !flush;
  assign hi_o  = r_hi;
  assign lo_o  = r_lo;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_opa     <= 32'd0;
      r_opb     <= 32'd0;
      r_rem     <= 32'd0;
      r_quot    <= 32'd0;
      r_cnt     <= 5'd0;
      r_mul_sgn <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
    end else if (!flush) begin
      case (r_state)
        S_IDLE: begin
          if (w_is_mul) begin
            r_opa     <= a;
            r_opb     <= b;
            r_mul_sgn <= (alucontrol == `MULT_CONTROL);
            r_cnt     <= 5'd0;
          end else if (w_is_div) begin
            if (b != 32'd0) begin
              r_quot  <= (w_sdiv && a[31]) ? -a : a;
              r_opb   <= (w_sdiv && b[31]) ? -b : b;
              r_rem   <= 32'd0;
              r_neg_q <= w_sdiv && (a[31] ^ b[31]);
              r_neg_r <= w_sdiv && a[31];
              r_cnt   <= 5'd0;
            end
          end else if (w_is_mthi) begin
            r_hi <= a;
          end else if (w_is_mtlo) begin
            r_lo <= a;
          end
        end
        S_MUL: begin
          r_cnt <= r_cnt + 5'd1;
          if (w_mul_last) {r_hi, r_lo} <= w_prod;
        end
        S_DIV: begin
          r_rem  <= w_rem_nxt;
          r_quot <= w_quot_nxt;
          r_cnt  <= r_cnt + 5'd1;
        end
        S_FIX: begin
          r_lo <= r_neg_q ? -r_quot : r_quot;
          r_hi <= r_neg_r ? -r_rem  : r_rem;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Execute-stage consumer of the 5-bit ALU control code for the HI/LO instruction class: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- Owns the HI and LO architectural registers; MFHI/MFLO read them through hi_o/lo_o.
- Multiply has a fixed small latency; divide is an iterative radix-2 restoring divider.
- Stalls the pipeline until each result is committed.

Parameters:
- MUL_LAT, 1, cycles spent in MUL state before product commit (legal 1..4).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- start  in  1  EX holds a valid instruction whose decoded control is alucontrol.
- alucontrol  in  5  decoded ALU control code; uses `MULT_CONTROL`, `MULTU_CONTROL`, `DIV_CONTROL`, `DIVU_CONTROL`, `MTHI_CONTROL`, `MTLO_CONTROL`; other codes are ignored.
- a  in  32  rs operand (dividend / multiplicand / MTHI-MTLO source).
- b  in  32  rt operand (divisor / multiplier).
- flush  in  1  exception/cancel; discards the in-flight operation.
- stall  out  1  hold EX and earlier stages.
- done  out  1  one-cycle pulse: mul/div result committed (or divide-by-zero completed).
- hi_o  out  32  current HI.
- lo_o  out  32  current LO.

Behaviour:
- Reset (resetn=0, async): state=IDLE, hi=lo=0, counter=0, done=0; stall=0 combinationally.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE, start=1, flush=0:
  - MULT/MULTU: latch operands; go to MUL.
  - DIV/DIVU with b!=0: latch |a| and |b| (signed ops) or raw a and b (unsigned ops), record sign bits, counter=0; go to DIV.
  - DIV/DIVU with b==0: go to DONE; HI/LO unchanged.
  - MTHI: hi<=a. MTLO: lo<=a. Takes effect at the same edge; no state change, no stall.
- MUL:
  - Runs MUL_LAT cycles.
  - On the last cycle: {hi,lo}<=64-bit product, signed for MULT, unsigned for MULTU; go to DONE.
- DIV:
  - One restoring step per cycle: shift {rem,quot} left 1, trial-subtract divisor, set quotient bit if the result is non-negative.
  - Exactly 32 cycles (counter 0..31); then go to FIX.
- FIX:
  - Signed: quotient negated if a[31]^b[31]; remainder negated if a[31].
  - lo<=quotient, hi<=remainder; go to DONE.
- DONE:
  - done=1 for this cycle; stall=0; next state IDLE.
  - start is ignored here, because the same instruction is still in EX this cycle; no restart.
- stall:
  - Asserted when (state==IDLE and start and op is MULT/MULTU/DIV/DIVU and !flush), or state is MUL, DIV or FIX.
  - Deasserted in DONE and in IDLE otherwise.
- Latency (cycles with stall=1): MULT/MULTU = 1+MUL_LAT; DIV/DIVU = 1+32+1 = 34; divide-by-zero = 1.
- hi_o/lo_o are direct register outputs, so a committed result is visible in the DONE cycle to a following MFHI/MFLO.
- flush:
  - Any state with flush=1: next state IDLE; no HI/LO write, including MTHI/MTLO in the same cycle; done=0.
  - stall drops combinationally the cycle flush is seen.
- Signed edge case: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (wraps, no trap).
- Unrecognised alucontrol with start=1: no effect.

Test Plan:
- MULT a=0xFFFFFFFE b=3, MUL_LAT=1 -> stall high 2 cycles, done pulse, hi=0xFFFFFFFF lo=0xFFFFFFFA.
- MULTU a=0xFFFFFFFE b=3 -> hi=0x00000002 lo=0xFFFFFFFA.
- DIV a=0xFFFFFFF9 (-7) b=2 -> stall 34 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=14, hi=2.
- DIVU a=100 b=0, hi/lo preloaded 0x11/0x22 -> stall 1 cycle, done pulse, hi=0x11 lo=0x22.
- DIV started, flush on iteration 10 -> IDLE next cycle, stall low, no done, hi/lo unchanged; a new MULT then proceeds normally.
- MTHI a=0x12345678 -> hi_o=0x12345678 after one edge, stall never high. resetn low mid-DIV -> hi=lo=0 and stall=0 immediately, no clock edge required.
